// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control encodings, checker FSM states and golden model
package alu_pkg;

  localparam int GOLD_W = 64;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } chk_state_e;

  // Computed wide; callers truncate to their operand width, which keeps the result modulo 2^WIDTH.
  function automatic logic [GOLD_W-1:0] alu_golden(input logic [GOLD_W-1:0] op1,
                                                   input logic [GOLD_W-1:0] op2,
                                                   input logic [1:0]        ctrl);
    logic [GOLD_W-1:0] res;
    case (alu_ctrl_e'(ctrl))
      ALU_AND: res = op1 & op2;
      ALU_OR:  res = op1 | op2;
      ALU_ADD: res = op1 + op2;
      default: res = op1 - op2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_result_checker_if.sv
// rtl/alu_result_checker_if.sv - operand/control to result/Zero bundle between ALU driver and checker
interface alu_result_checker_if #(parameter int WIDTH = 32);
  logic             op_valid;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [1:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;

  modport master (output op_valid, Operand1, Operand2, ALUControl, ALUResult, Zero);
  modport slave  (input  op_valid, Operand1, Operand2, ALUControl, ALUResult, Zero);
endinterface

// File: rtl/alu_check_delay.sv
// rtl/alu_check_delay.sv - valid-tagged shift register with synchronous flush; depth 0 is a wire
module alu_check_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_busy
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, i_flush};
      assign o_valid  = i_valid;
      assign o_data   = i_data;
      assign o_busy   = 1'b0;
    end else begin : g_dly
      logic [DEPTH-1:0] r_valid;
      logic [W-1:0]     r_data [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= '0;
          for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else if (i_flush) begin
          r_valid <= '0;
        end else begin
          r_valid[0] <= i_valid;
          r_data[0]  <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_data[i]  <= r_data[i-1];
          end
        end
      end

      assign o_valid = r_valid[DEPTH-1];
      assign o_data  = r_data[DEPTH-1];
      assign o_busy  = |r_valid;
    end
  endgenerate

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - recomputes ALU results, compares after LATENCY cycles, counts and
// captures the first failure of each run
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_checks,
  alu_result_checker_if.slave  alu,
  output logic                 check_valid,
  output logic                 check_pass,
  output logic [CNT_W-1:0]     check_count,
  output logic [CNT_W-1:0]     error_count,
  output logic                 error,
  output logic [WIDTH-1:0]     fail_op1,
  output logic [WIDTH-1:0]     fail_op2,
  output logic [WIDTH-1:0]     fail_result,
  output logic [1:0]           fail_ctrl,
  output logic                 done
);

  localparam int PW = 3 * WIDTH + 3;

  chk_state_e       r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issued;
  logic             r_cmp_valid;
  logic [PW-1:0]    r_cmp_pl;
  logic [WIDTH-1:0] r_cmp_res;
  logic             r_cmp_zero;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_gold;
  logic [PW-1:0]    w_pl;
  logic             w_dly_valid;
  logic [PW-1:0]    w_dly_pl;
  logic             w_dly_busy;
  logic [WIDTH-1:0] w_exp_res;
  logic             w_exp_zero;
  logic [WIDTH-1:0] w_c_op1;
  logic [WIDTH-1:0] w_c_op2;
  logic [1:0]       w_c_ctrl;
  logic             w_mismatch;

  // start takes priority over an op in the same cycle so a restart never counts a stale op
  assign w_accept = (r_state == S_RUN) && alu.op_valid && !start;
  assign w_last   = w_accept && (r_num != '0) && (r_issued == r_num - CNT_W'(1));
  assign w_gold   = WIDTH'(alu_golden(GOLD_W'(alu.Operand1), GOLD_W'(alu.Operand2), alu.ALUControl));
  assign w_pl     = {w_gold, (w_gold == '0), alu.Operand1, alu.Operand2, alu.ALUControl};

  alu_check_delay #(.W(PW), .DEPTH(LATENCY)) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (start),
    .i_valid (w_accept),
    .i_data  (w_pl),
    .o_valid (w_dly_valid),
    .o_data  (w_dly_pl),
    .o_busy  (w_dly_busy)
  );

  assign {w_exp_res, w_exp_zero, w_c_op1, w_c_op2, w_c_ctrl} = r_cmp_pl;
  assign w_mismatch = (r_cmp_res != w_exp_res) || (r_cmp_zero != w_exp_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_issued    <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_pl    <= '0;
      r_cmp_res   <= '0;
      r_cmp_zero  <= 1'b0;
      check_valid <= 1'b0;
      check_pass  <= 1'b0;
      check_count <= '0;
      error_count <= '0;
      error       <= 1'b0;
      fail_op1    <= '0;
      fail_op2    <= '0;
      fail_result <= '0;
      fail_ctrl   <= '0;
      done        <= 1'b0;
    end else if (start) begin
      r_state     <= S_RUN;
      r_num       <= num_checks;
      r_issued    <= '0;
      r_cmp_valid <= 1'b0;
      check_valid <= 1'b0;
      check_pass  <= 1'b0;
      check_count <= '0;
      error_count <= '0;
      error       <= 1'b0;
      fail_op1    <= '0;
      fail_op2    <= '0;
      fail_result <= '0;
      fail_ctrl   <= '0;
      done        <= 1'b0;
    end else begin
      // ALU outputs are captured alongside the delayed golden entry, compared one cycle later
      r_cmp_valid <= w_dly_valid;
      r_cmp_pl    <= w_dly_pl;
      r_cmp_res   <= alu.ALUResult;
      r_cmp_zero  <= alu.Zero;
      check_valid <= r_cmp_valid;
      check_pass  <= r_cmp_valid && !w_mismatch;
      if (r_cmp_valid) begin
        if (check_count != '1) check_count <= check_count + CNT_W'(1);
        if (w_mismatch) begin
          if (error_count != '1) error_count <= error_count + CNT_W'(1);
          error <= 1'b1;
          if (!error) begin
            fail_op1    <= w_c_op1;
            fail_op2    <= w_c_op2;
            fail_result <= r_cmp_res;
            fail_ctrl   <= w_c_ctrl;
          end
        end
      end
      if (w_accept) r_issued <= r_issued + CNT_W'(1);
      case (r_state)
        S_RUN:   if (w_last) r_state <= S_DRAIN;
        S_DRAIN: if (!w_dly_busy && !r_cmp_valid) begin
          r_state <= S_DONE;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - scoreboard bench: LATENCY=0/CNT_W=16 and LATENCY=3/CNT_W=4 instances
module tb_alu_result_checker;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  alu_result_checker_if #(.WIDTH(32)) ia();
  alu_result_checker_if #(.WIDTH(32)) ib();

  logic        a_start, a_cv, a_cp, a_err, a_done;
  logic [15:0] a_num, a_cc, a_ec;
  logic [31:0] a_fop1, a_fop2, a_fres;
  logic [1:0]  a_fctrl;

  logic        b_start, b_cv, b_cp, b_err, b_done;
  logic [3:0]  b_num, b_cc, b_ec;
  logic [31:0] b_fop1, b_fop2, b_fres;
  logic [1:0]  b_fctrl;

  alu_result_checker #(.WIDTH(32), .LATENCY(0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .num_checks(a_num), .alu(ia),
    .check_valid(a_cv), .check_pass(a_cp), .check_count(a_cc), .error_count(a_ec),
    .error(a_err), .fail_op1(a_fop1), .fail_op2(a_fop2), .fail_result(a_fres),
    .fail_ctrl(a_fctrl), .done(a_done));

  alu_result_checker #(.WIDTH(32), .LATENCY(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_checks(b_num), .alu(ib),
    .check_valid(b_cv), .check_pass(b_cp), .check_count(b_cc), .error_count(b_ec),
    .error(b_err), .fail_op1(b_fop1), .fail_op2(b_fop2), .fail_result(b_fres),
    .fail_ctrl(b_fctrl), .done(b_done));

  bit qa[$];
  bit qb[$];
  int a_seen = 0, b_seen = 0, a_last_cv = -1, b_last_cv = -1, b_first_cv = -1;
  logic [31:0] b_hist [4];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tb_gold(input logic [31:0] x, input logic [31:0] y,
                                          input logic [1:0] c);
    case (c)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x + y;
      default: return x - y;
    endcase
  endfunction

  always @(negedge clk) begin
    if (a_cv === 1'b1) begin
      a_seen++;
      a_last_cv = cyc;
      if (qa.size() == 0) check_eq("a_unexpected_check", a_cv, 0);
      else check_eq("a_check_pass", a_cp, qa.pop_front());
    end
    if (b_cv === 1'b1) begin
      b_seen++;
      b_last_cv = cyc;
      if (b_first_cv < 0) b_first_cv = cyc;
      if (qb.size() == 0) check_eq("b_unexpected_check", b_cv, 0);
      else check_eq("b_check_pass", b_cp, qb.pop_front());
    end
  end

  task automatic a_pulse(input logic [15:0] n);
    a_num = n; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic a_op(input logic [31:0] x, input logic [31:0] y, input logic [1:0] c,
                      input logic [31:0] res, input logic z);
    logic [31:0] g;
    g = tb_gold(x, y, c);
    ia.op_valid = 1'b1; ia.Operand1 = x; ia.Operand2 = y; ia.ALUControl = c;
    ia.ALUResult = res; ia.Zero = z;
    qa.push_back((res == g) && (z == (g == 32'd0)));
    @(posedge clk); #1;
  endtask

  task automatic a_wait_done(input int max_cyc);
    ia.op_valid = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (a_done) break;
    end
    check_eq("a_done", a_done, 1);
    check_eq("a_done_after_last_check", cyc - a_last_cv, 1);
  endtask

  // Models an ALU with a 3-cycle result latency for the B instance.
  task automatic b_step(input bit v, input logic [31:0] x, input logic [31:0] y,
                        input logic [1:0] c, input bit expect_chk);
    for (int i = 3; i > 0; i--) b_hist[i] = b_hist[i-1];
    b_hist[0] = tb_gold(x, y, c);
    ib.op_valid = v; ib.Operand1 = x; ib.Operand2 = y; ib.ALUControl = c;
    ib.ALUResult = b_hist[3]; ib.Zero = (b_hist[3] == 32'd0);
    if (expect_chk) qb.push_back(1'b1);
    @(posedge clk); #1;
  endtask

  task automatic b_pulse(input logic [3:0] n);
    b_num = n; b_start = 1'b1;
    b_step(0, 0, 0, 0, 0);
    b_start = 1'b0;
  endtask

  task automatic b_wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      b_step(0, 0, 0, 0, 0);
      @(negedge clk);
      if (b_done) break;
    end
    check_eq("b_done", b_done, 1);
    check_eq("b_done_after_last_check", cyc - b_last_cv, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, t0;
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; a_num = '0; b_num = '0;
    ia.op_valid = 1'b0; ia.Operand1 = '0; ia.Operand2 = '0; ia.ALUControl = '0;
    ia.ALUResult = '0; ia.Zero = 1'b0;
    ib.op_valid = 1'b0; ib.Operand1 = '0; ib.Operand2 = '0; ib.ALUControl = '0;
    ib.ALUResult = '0; ib.Zero = 1'b0;
    for (int i = 0; i < 4; i++) b_hist[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_check_count", a_cc, 0);
    check_eq("rst_a_error", a_err, 0);
    check_eq("rst_a_done", a_done, 0);
    check_eq("rst_a_check_valid", a_cv, 0);
    check_eq("rst_a_fail_op1", a_fop1, 0);
    check_eq("rst_b_error_count", b_ec, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // all four ops on a correct ALU
    a_pulse(16'd4);
    s = a_seen;
    a_op(32'd85, 32'd16554, 2'b00, 32'd0, 1'b1);
    a_op(32'd85, 32'd16554, 2'b01, 32'd16639, 1'b0);
    a_op(32'd85, 32'd16554, 2'b10, 32'd16639, 1'b0);
    a_op(32'd85, 32'd16554, 2'b11, 32'hFFFF_BFAB, 1'b0);
    a_wait_done(20);
    check_eq("t1_checks_seen", a_seen - s, 4);
    check_eq("t1_check_count", a_cc, 4);
    check_eq("t1_error_count", a_ec, 0);
    check_eq("t1_error", a_err, 0);

    // Zero flag mismatch on SUB with equal operands
    a_pulse(16'd2);
    a_op(32'd85, 32'd85, 2'b11, 32'd0, 1'b1);
    a_op(32'd85, 32'd85, 2'b11, 32'd0, 1'b0);
    a_wait_done(20);
    check_eq("t2_error", a_err, 1);
    check_eq("t2_error_count", a_ec, 1);
    check_eq("t2_fail_ctrl", a_fctrl, 2'b11);
    check_eq("t2_fail_op1", a_fop1, 85);
    check_eq("t2_fail_result", a_fres, 0);

    // two faults: only the first (AND) is captured
    a_pulse(16'd3);
    a_op(32'hF0F0_1234, 32'h0FF0_00FF, 2'b00, 32'h00F0_0035, 1'b0);
    a_op(32'hF0F0_1234, 32'h0FF0_00FF, 2'b01, 32'hFFF0_12FF, 1'b0);
    a_op(32'hF0F0_1234, 32'h0FF0_00FF, 2'b10, 32'h00E0_1332, 1'b0);
    a_wait_done(20);
    check_eq("t3_error_count", a_ec, 2);
    check_eq("t3_check_count", a_cc, 3);
    check_eq("t3_fail_ctrl", a_fctrl, 2'b00);
    check_eq("t3_fail_op1", a_fop1, 32'hF0F0_1234);
    check_eq("t3_fail_op2", a_fop2, 32'h0FF0_00FF);
    check_eq("t3_fail_result", a_fres, 32'h00F0_0035);
    check_eq("t3_sb_empty", qa.size(), 0);

    // LATENCY=3, back-to-back ops
    b_pulse(4'd10);
    s = b_seen; b_first_cv = -1; t0 = 0;
    for (int i = 0; i < 10; i++) begin
      b_step(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1);
      if (i == 0) t0 = cyc;
    end
    b_wait_done(30);
    check_eq("t4_checks_seen", b_seen - s, 10);
    check_eq("t4_first_check_latency", b_first_cv - t0, 4);
    check_eq("t4_check_count", b_cc, 10);
    check_eq("t4_error_count", b_ec, 0);
    check_eq("t4_sb_empty", qb.size(), 0);

    // reset with ops in flight
    b_pulse(4'd0);
    for (int i = 0; i < 6; i++) b_step(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1);
    check_eq("t5_pre_reset_count", b_cc, 2);
    rst_n = 1'b0;
    qb.delete();
    #1;
    check_eq("t5_b_check_count", b_cc, 0);
    check_eq("t5_b_check_valid", b_cv, 0);
    check_eq("t5_b_done", b_done, 0);
    check_eq("t5_a_error", a_err, 0);
    check_eq("t5_a_error_count", a_ec, 0);
    check_eq("t5_a_fail_op1", a_fop1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s = b_seen;
    for (int i = 0; i < 4; i++) b_step(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 0);
    for (int i = 0; i < 6; i++) b_step(0, 0, 0, 0, 0);
    check_eq("t5_no_checks_after_reset", b_seen - s, 0);
    check_eq("t5_idle_count", b_cc, 0);

    // saturation of a 4-bit check counter
    b_pulse(4'd0);
    s = b_seen;
    for (int i = 0; i < 20; i++) b_step(1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1);
    for (int i = 0; i < 8; i++) b_step(0, 0, 0, 0, 0);
    check_eq("t6_checks_seen", b_seen - s, 20);
    check_eq("t6_check_count_sat", b_cc, 4'hF);
    check_eq("t6_error_count", b_ec, 0);
    check_eq("t6_sb_empty", qb.size(), 0);
    b_pulse(4'd0);
    check_eq("t6_cleared_by_start", b_cc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
